// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, error codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        RESP = 2'b10
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Lane steering: byte enables, replicated store data, extended load data, fault flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs track inputs.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    assign byte_lane = rdata[{offset, 3'b000} +: 8];
    assign half_lane = offset[1] ? rdata[31:16] : rdata[15:0];

    // Decode size/offset into enables, store replication and load extension.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = '0;
        rdata_ext = '0;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (size)
            SZ_B: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata[7:0]}};
                rdata_ext = {{24{~uns & byte_lane[7]}}, byte_lane};
            end
            SZ_H: begin
                be        = offset[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
                rdata_ext = {{16{~uns & half_lane[15]}}, half_lane};
                misalign  = offset[0];
            end
            SZ_W: begin
                be        = 4'b1111;
                wdata_rep = wdata;
                rdata_ext = rdata;
                misalign  = (offset != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one byte/half/word access per request over a req/ack memory bus.
// Latency: 1 cycle accept-to-response on faults, >= 2 cycles on bus accesses.
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack or TIMEOUT cycles.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [1:0]  resp_err,
    output logic [31:0] resp_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t      state, state_nxt;
    logic [1:0]  size_q, off_q;
    logic        uns_q;
    logic [7:0]  cnt;
    logic        accept;
    logic [1:0]  err_nxt;
    logic [31:0] rdata_nxt;

    logic [1:0]  a_size, a_off;
    logic        a_uns;
    logic [3:0]  a_be;
    logic [31:0] a_wdata, a_rdata;
    logic        a_misalign, a_illegal;

    assign req_ready = (state == IDLE) && reset;
    assign accept    = req_valid && req_ready;
    assign mem_req   = (state == BUSY);

    // One steering block serves both directions: the live request in IDLE
    // (store lanes, fault checks) and the latched request afterwards (load extension).
    assign a_size = (state == IDLE) ? req_size     : size_q;
    assign a_off  = (state == IDLE) ? req_addr[1:0] : off_q;
    assign a_uns  = (state == IDLE) ? req_unsigned : uns_q;

    lsu_align u_align (
        .size      (a_size),
        .offset    (a_off),
        .uns       (a_uns),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .be        (a_be),
        .wdata_rep (a_wdata),
        .rdata_ext (a_rdata),
        .misalign  (a_misalign),
        .illegal   (a_illegal)
    );

    // State register; reset drops any outstanding access without a response.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus the response payload to register on the transition into RESP.
    always_comb begin
        state_nxt = state;
        err_nxt   = ERR_OK;
        rdata_nxt = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (a_illegal) begin
                        err_nxt   = ERR_SIZE;
                        state_nxt = RESP;
                    end else if (a_misalign) begin
                        err_nxt   = ERR_MISALIGN;
                        state_nxt = RESP;
                    end else begin
                        state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                // Ack is checked first so it wins over a same-cycle expiry.
                if (mem_ack) begin
                    rdata_nxt = mem_we ? 32'h0 : a_rdata;
                    state_nxt = RESP;
                end else if (cnt == 8'(TIMEOUT - 1)) begin
                    err_nxt   = ERR_TIMEOUT;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latches, wait counter and registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            size_q     <= '0;
            off_q      <= '0;
            uns_q      <= 1'b0;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= ERR_OK;
            resp_rdata <= '0;
        end else begin
            if (accept) begin
                mem_we    <= req_we;
                mem_addr  <= {req_addr[31:2], 2'b00};
                mem_be    <= a_be;
                mem_wdata <= a_wdata;
                size_q    <= req_size;
                off_q     <= req_addr[1:0];
                uns_q     <= req_unsigned;
            end
            cnt        <= (state == BUSY) ? cnt + 8'd1 : 8'd0;
            resp_valid <= (state_nxt == RESP);
            resp_err   <= err_nxt;
            resp_rdata <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with TIMEOUT=4: loads, stores, faults, timeout, reset mid-access.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: mem_ack driven by the bench at hand-chosen cycles.
module tb_lsu;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [1:0]  resp_err;
    logic [31:0] resp_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;

    lsu #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_be       (mem_be),
        .mem_wdata    (mem_wdata),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Present a request for one edge; returns in the cycle after the accept edge.
    task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd);
        chk1("ready_before_issue", req_ready, 1'b1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        mem_ack = 1'b0; mem_rdata = '0;

        // Reset state
        @(negedge clk); @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk ("rst_mem_addr", mem_addr, 32'h0);
        chk ("rst_mem_be", 32'(mem_be), 32'h0);
        chk ("rst_mem_wdata", mem_wdata, 32'h0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk ("rst_resp_err", 32'(resp_err), 32'h0);
        chk ("rst_resp_rdata", resp_rdata, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk1("ready_after_release", req_ready, 1'b1);

        // Load byte, signed, ack in first BUSY cycle
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0);
        chk1("lb_mem_req", mem_req, 1'b1);
        chk1("lb_mem_we", mem_we, 1'b0);
        chk ("lb_mem_addr", mem_addr, 32'h0000_0100);
        chk ("lb_mem_be", 32'(mem_be), 32'h8);
        chk1("lb_no_resp_yet", resp_valid, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h80FF_1234;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("lb_resp_valid", resp_valid, 1'b1);
        chk ("lb_resp_err", 32'(resp_err), 32'h0);
        chk ("lb_resp_rdata", resp_rdata, 32'hFFFF_FF80);
        chk1("lb_mem_req_fall", mem_req, 1'b0);
        chk1("lb_ready_in_resp", req_ready, 1'b0);
        @(negedge clk);
        chk1("lb_resp_pulse_end", resp_valid, 1'b0);
        chk ("lb_rdata_cleared", resp_rdata, 32'h0);

        // Load half, unsigned, upper lane
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'h0);
        chk ("lhu_mem_be", 32'(mem_be), 32'hC);
        chk ("lhu_mem_addr", mem_addr, 32'h0000_0020);
        mem_ack = 1'b1; mem_rdata = 32'hBEEF_0000;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("lhu_resp_valid", resp_valid, 1'b1);
        chk ("lhu_resp_rdata", resp_rdata, 32'h0000_BEEF);
        @(negedge clk);

        // Load half, signed, lower lane
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0020, 32'h0);
        chk ("lh_mem_be", 32'(mem_be), 32'h3);
        mem_ack = 1'b1; mem_rdata = 32'h1234_8001;
        @(negedge clk);
        mem_ack = 1'b0;
        chk ("lh_resp_rdata", resp_rdata, 32'hFFFF_8001);
        @(negedge clk);

        // Store byte, ack after 3 wait cycles (4th BUSY cycle coincides with expiry)
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0041, 32'h1234_56AB);
        mem_rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            chk1("sb_mem_req", mem_req, 1'b1);
            chk1("sb_mem_we", mem_we, 1'b1);
            chk ("sb_mem_be", 32'(mem_be), 32'h2);
            chk ("sb_mem_wdata", mem_wdata, 32'hABAB_ABAB);
            chk ("sb_mem_addr", mem_addr, 32'h0000_0040);
            chk1("sb_no_resp", resp_valid, 1'b0);
            if (i == 3) mem_ack = 1'b1;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk1("sb_resp_valid", resp_valid, 1'b1);
        chk ("sb_resp_err", 32'(resp_err), 32'h0);
        chk ("sb_resp_rdata", resp_rdata, 32'h0);
        chk1("sb_mem_req_fall", mem_req, 1'b0);
        @(negedge clk);

        // Misaligned word
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0202, 32'h0);
        chk1("mis_resp_valid", resp_valid, 1'b1);
        chk ("mis_resp_err", 32'(resp_err), 32'h1);
        chk1("mis_no_mem_req", mem_req, 1'b0);
        @(negedge clk);
        chk1("mis_no_mem_req2", mem_req, 1'b0);
        chk1("mis_pulse_end", resp_valid, 1'b0);

        // Misaligned half
        issue(1'b1, 2'b01, 1'b0, 32'h0000_0101, 32'h0);
        chk ("mish_resp_err", 32'(resp_err), 32'h1);
        chk1("mish_no_mem_req", mem_req, 1'b0);
        @(negedge clk);

        // Illegal size
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0200, 32'h0);
        chk1("ill_resp_valid", resp_valid, 1'b1);
        chk ("ill_resp_err", 32'(resp_err), 32'h3);
        chk1("ill_no_mem_req", mem_req, 1'b0);
        @(negedge clk);
        chk1("ill_no_mem_req2", mem_req, 1'b0);

        // Timeout, no ack
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0300, 32'h0);
        for (int i = 0; i < 4; i++) begin
            chk1("to_mem_req", mem_req, 1'b1);
            chk1("to_no_resp", resp_valid, 1'b0);
            @(negedge clk);
        end
        chk1("to_mem_req_fall", mem_req, 1'b0);
        chk1("to_resp_valid", resp_valid, 1'b1);
        chk ("to_resp_err", 32'(resp_err), 32'h2);
        chk ("to_resp_rdata", resp_rdata, 32'h0);
        @(negedge clk);

        // Ack in the 4th cycle beats expiry, word load
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0304, 32'h0);
        chk ("w_mem_be", 32'(mem_be), 32'hF);
        @(negedge clk); @(negedge clk); @(negedge clk);
        chk1("w_still_req", mem_req, 1'b1);
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("w_resp_valid", resp_valid, 1'b1);
        chk ("w_resp_err", 32'(resp_err), 32'h0);
        chk ("w_resp_rdata", resp_rdata, 32'hCAFE_F00D);
        @(negedge clk);

        // Reset mid-BUSY
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0400, 32'h0);
        chk1("rb_mem_req", mem_req, 1'b1);
        reset = 1'b0;
        @(negedge clk);
        chk1("rb_mem_req_drop", mem_req, 1'b0);
        chk1("rb_ready_low", req_ready, 1'b0);
        chk1("rb_no_resp", resp_valid, 1'b0);
        chk ("rb_mem_addr_clr", mem_addr, 32'h0);
        reset = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("rb_late_ack_ignored", resp_valid, 1'b0);
        chk1("rb_mem_req_idle", mem_req, 1'b0);
        chk1("rb_ready_release", req_ready, 1'b1);
        @(negedge clk);
        chk1("rb_still_no_resp", resp_valid, 1'b0);

        // Normal operation after reset: unsigned byte, lane 0
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0500, 32'h0);
        chk ("post_mem_be", 32'(mem_be), 32'h1);
        mem_ack = 1'b1; mem_rdata = 32'h0000_00F0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk ("post_resp_rdata", resp_rdata, 32'h0000_00F0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit directly downstream of `alu`: consumes the ALU result as an effective address and executes one byte, half or word memory access per request over a simple req/ack data-memory bus. Responses carry sign- or zero-extended load data. Misaligned accesses, illegal sizes and bus timeouts are reported as error codes. Holds the core in stall via `req_ready` while an access is outstanding.

## Interface
- `TIMEOUT`, 16: cycles `mem_req` may stay high without `mem_ack` before the access is aborted (range 1–255).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  LSU can accept a request; high only in IDLE, and 0 while `reset` is low.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- `req_addr`  in  32  effective address (ALU `res`).
- `req_wdata`  in  32  store data in the low bits.
- `resp_valid`  out  1  one-cycle response pulse.
- `resp_err`  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal size.
- `resp_rdata`  out  32  extended load data; 0 for stores and errors.
- `mem_req`  out  1  bus request, held until ack or timeout.
- `mem_we`  out  1  bus write.
- `mem_addr`  out  32  `{req_addr[31:2], 2'b00}`.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  bus completion; ignored while `mem_req` is 0.
- `mem_rdata`  in  32  read word, valid with `mem_ack`.

## Operation
- **FSM states:** IDLE, BUSY, RESP.
- **IDLE:** a request is accepted when `req_valid && req_ready`. Address, size, `req_we`, `req_unsigned` and the pre-steered write data/enables are registered.
  - Illegal size or misaligned access goes to RESP with the error latched; no bus access. Misaligned means half with `addr[0]=1`, or word with `addr[1:0]!=0`.
  - Otherwise go to BUSY.
- **BUSY:** `mem_req`=1 and all `mem_*` outputs are stable. The timeout counter starts at 0 on entry and increments every BUSY cycle.
  - `mem_ack`=1: capture the extended `mem_rdata` (or 0 for stores), set err 00, go to RESP.
  - Otherwise, counter reaching `TIMEOUT-1`: set err 10, go to RESP.
  - Ack and expiry in the same cycle: ack wins.
- **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE. `req_ready`=0 in RESP, so back-to-back requests are spaced by at least one IDLE cycle.
- **Byte enables:** byte `4'b0001 << addr[1:0]`; half `addr[1]` ? `1100` : `0011`; word `1111`.
- **Write data:** byte `{4{wdata[7:0]}}`, half `{2{wdata[15:0]}}`, word unchanged.
- **Load data:**
  - Byte lane `addr[1:0]`, half lane `addr[1]`.
  - Bit 7 or bit 15 replicated when `req_unsigned`=0, zeros otherwise.
  - Word loads pass through unchanged.
- **Reset:** `reset`=0 at an edge forces IDLE and clears all registers, even mid-BUSY. Any outstanding access is dropped without a response, and a late `mem_ack` is ignored.

## Timing
- **Reset values:** `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata`, `resp_valid`, `resp_err` and `resp_rdata` are all 0. `req_ready` is 0 during reset and 1 on the first cycle after release.
- **Accept:** occurs at edge N.
  - Error path: `resp_valid` in cycle N+1.
  - Bus path: `mem_req` rises in cycle N+1.
- **Ack:** with ack in BUSY cycle k, `mem_req` falls and `resp_valid` is high in cycle k+1. Minimum load latency is therefore 2 cycles from accept to response.
- **Timeout:** `mem_req` is high for exactly `TIMEOUT` cycles, then `resp_valid` with err 10.
- `resp_*` outputs are registered and return to 0 when `resp_valid` drops.

## Structure
- **Package `lsu_pkg`:**
  - Size encodings `SZ_B`/`SZ_H`/`SZ_W`.
  - Error codes `ERR_OK`/`ERR_MISALIGN`/`ERR_TIMEOUT`/`ERR_SIZE`.
  - State enum IDLE/BUSY/RESP.
- **Sub-module `lsu_align`:** combinational; takes size, offset and unsigned flag. Produces `mem_be`, replicated write data, extended load data and the misaligned/illegal flags.
- **`lsu`:** contains the FSM, the timeout counter and the registers.

## Test plan
- **Load byte, signed:** `addr`=0x103, size 00, `req_unsigned`=0, ack in the first BUSY cycle with `mem_rdata`=0x80FF_1234. Expect `mem_addr`=0x100, `mem_be`=1000, `resp_rdata`=0xFFFF_FF80, err 00, response 2 cycles after accept.
- **Load half, unsigned:** `addr`=0x22, `mem_rdata`=0xBEEF_0000. Expect `mem_be`=1100, `resp_rdata`=0x0000_BEEF.
- **Store byte:** `addr`=0x41, `wdata`=0x1234_56AB, ack after 3 wait cycles. Expect `mem_we`=1, `mem_be`=0010, `mem_wdata`=0xABAB_ABAB held stable 4 cycles, `resp_rdata`=0.
- **Misaligned and illegal:** word at 0x202 gives err 01 and size 11 at 0x200 gives err 11, each with `resp_valid` 1 cycle after accept and `mem_req` never asserted.
- **Timeout:** `TIMEOUT`=4, no ack. Expect `mem_req` high for exactly 4 cycles, then err 10. Repeat with ack in the 4th cycle: expect err 00.
- **Reset mid-BUSY:** `reset`=0 for one edge while waiting for ack. Expect `mem_req`=0 and `req_ready`=0 the next cycle, no `resp_valid`, a later `mem_ack` ignored, and `req_ready`=1 after release.
